// File: rtl/sad_best_match.sv
// Collects NUM_CAND SAD results from the SAD core over a done/ack handshake and
// reports the minimum SAD and its arrival index via a valid/ack handshake.
module sad_best_match #(
    parameter int WIDTH    = 8,
    parameter int NUM_CAND = 16,
    parameter int IDX_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH+4:0]   sad_in,
    input  logic               sad_valid,
    output logic               sad_ack,
    output logic [WIDTH+4:0]   best_sad,
    output logic [IDX_W-1:0]   best_idx,
    output logic               result_valid,
    input  logic               result_ack,
    output logic               busy
);
    localparam int CW = IDX_W + 1;

    typedef enum logic [2:0] {IDLE, COLLECT, ACK, WAIT_LOW, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            clear, capture;

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (sad_valid) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: state_nxt = WAIT_LOW;
            // a done held high by the core must not be captured twice
            WAIT_LOW: begin
                if (!sad_valid)
                    state_nxt = (count == CW'(NUM_CAND)) ? DONE : COLLECT;
            end
            DONE: begin
                if (result_ack) begin
                    if (start) begin
                        clear     = 1'b1;
                        state_nxt = COLLECT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            best_sad <= '0;
            best_idx <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                count    <= '0;
                best_sad <= '0;
                best_idx <= '0;
            end else if (capture) begin
                // strict compare keeps the earliest index on ties
                if (count == '0 || sad_in < best_sad) begin
                    best_sad <= sad_in;
                    best_idx <= count[IDX_W-1:0];
                end
                count <= count + CW'(1);
            end
        end
    end

    assign sad_ack      = (state == ACK);
    assign result_valid = (state == DONE);
    assign busy         = (state == COLLECT) || (state == ACK) || (state == WAIT_LOW);

endmodule
